// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mac_pkg
// Description : Shared types and default constants for the mac operand feeder
//               and the mac block it drives.
// Revision    : 1.0 - initial release
// ============================================================================
package mac_pkg;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_MAC_LAT = 1;

    // Feeder sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feeder_state_t;

endpackage
`default_nettype wire

// File: rtl/mac_operand_buf.sv
`default_nettype none
// ============================================================================
// Module      : mac_operand_buf
// Description : DEPTH x (2*DATA_W) operand register file. One synchronous
//               write port, one combinational read port. Contents are not
//               reset.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_operand_buf
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_a,
    input  logic [DATA_W-1:0] wr_b,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_a,
    output logic [DATA_W-1:0] rd_b
);

    logic [2*DATA_W-1:0] r_mem [DEPTH];

    // Store the operand pair {a, b} at the write index
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= {wr_a, wr_b};
        end
    end

    assign rd_a = r_mem[rd_addr][2*DATA_W-1:DATA_W];
    assign rd_b = r_mem[rd_addr][DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/mac_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : mac_operand_feeder
// Description : Buffers two operand vectors and, on start, streams them
//               pair-by-pair into an external mac, driving accumulate so the
//               first pair restarts the sum. Captures mac_out after MAC_LAT
//               cycles and presents it as the dot-product result.
//               Optional macro FEEDER_OVF_EN adds a wide shadow accumulator
//               that flags when the true dot product exceeds DATA_W bits.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_operand_feeder
    import mac_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int MAC_LAT = DEF_MAC_LAT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [DATA_W-1:0]          wr_a,
    input  logic [DATA_W-1:0]          wr_b,
    input  logic                       start,
    input  logic [$clog2(DEPTH):0]     len,
    output logic                       busy,
    output logic                       done,
    output logic [DATA_W-1:0]          result,
    output logic                       result_ovf,
    output logic [DATA_W-1:0]          mac_a,
    output logic [DATA_W-1:0]          mac_b,
    output logic                       mac_acc,
    input  logic [DATA_W-1:0]          mac_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = 2;

    localparam logic [LW-1:0] c_depth      = LW'(DEPTH);
    localparam logic [DW-1:0] c_drain_last = DW'((MAC_LAT > 1) ? (MAC_LAT - 2) : 0);

    feeder_state_t r_state;
    feeder_state_t w_state_n;

    logic [LW-1:0]     r_cnt;
    logic [LW-1:0]     r_len;
    logic [DW-1:0]     r_drain;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_result;
    logic [DATA_W-1:0] r_mac_a;
    logic [DATA_W-1:0] r_mac_b;
    logic              r_mac_acc;

    logic [AW-1:0]     w_idx;
    logic              w_we;
    logic [LW-1:0]     w_len_clamp;
    logic [DATA_W-1:0] w_rd_a;
    logic [DATA_W-1:0] w_rd_b;
    logic [DATA_W-1:0] w_src_a;
    logic [DATA_W-1:0] w_src_b;
    logic              w_launch;
    logic              w_issue;
    logic              w_flush;
    logic              w_capture;

    assign w_idx       = r_cnt[AW-1:0];
    assign w_we        = wr_en & ~r_busy;
    assign w_len_clamp = (len > c_depth) ? c_depth : len;

    mac_operand_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (w_we),
        .wr_addr (wr_addr),
        .wr_a    (wr_a),
        .wr_b    (wr_b),
        .rd_addr (w_idx),
        .rd_a    (w_rd_a),
        .rd_b    (w_rd_b)
    );

    // A write landing on the same edge as the first issue must be seen by the
    // pass, so forward write data when it targets the entry being read.
    assign w_src_a = (w_we && (wr_addr == w_idx)) ? wr_a : w_rd_a;
    assign w_src_b = (w_we && (wr_addr == w_idx)) ? wr_b : w_rd_b;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // Next-state and per-edge control decode
    always_comb begin
        w_state_n = r_state;
        w_launch  = 1'b0;
        w_issue   = 1'b0;
        w_flush   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_launch = 1'b1;
                    if (w_len_clamp == '0) begin
                        w_state_n = DONE;
                    end else begin
                        w_issue   = 1'b1;
                        w_state_n = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (r_cnt < r_len) begin
                    w_issue = 1'b1;
                end else begin
                    // All pairs issued: park operands, wait out the mac latency
                    w_flush   = 1'b1;
                    w_state_n = (MAC_LAT > 1) ? DRAIN : DONE;
                end
            end
            DRAIN: begin
                if (r_drain == c_drain_last) begin
                    w_state_n = DONE;
                end
            end
            DONE: begin
                // This edge is the capture edge; mac_out holds the final sum
                w_capture = 1'b1;
                w_state_n = IDLE;
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    // Counters, operand registers and result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_len     <= '0;
            r_drain   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_mac_a   <= '0;
            r_mac_b   <= '0;
            r_mac_acc <= 1'b0;
        end else begin
            r_done <= w_capture;
            if (w_launch) begin
                r_len  <= w_len_clamp;
                r_busy <= 1'b1;
            end
            if (w_issue) begin
                r_mac_a   <= w_src_a;
                r_mac_b   <= w_src_b;
                r_mac_acc <= (r_cnt != '0);
                r_cnt     <= r_cnt + 1'b1;
            end
            if (w_flush) begin
                r_mac_a   <= '0;
                r_mac_b   <= '0;
                r_mac_acc <= 1'b0;
                r_cnt     <= '0;
                r_drain   <= '0;
            end
            if (r_state == DRAIN) begin
                r_drain <= r_drain + 1'b1;
            end
            if (w_capture) begin
                r_busy   <= 1'b0;
                r_result <= (r_len == '0) ? '0 : mac_out;
            end
        end
    end

`ifdef FEEDER_OVF_EN
    localparam int SW = 2 * DATA_W + AW;
    localparam logic [SW-1:0] c_ovf_lim = SW'(1) << DATA_W;

    logic [SW-1:0] r_shadow;
    logic          r_ovf;
    logic [SW-1:0] w_prod;

    assign w_prod = SW'(w_src_a) * SW'(w_src_b);

    // Full-precision running sum of issued products; flags results that wrapped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_launch) begin
                r_ovf    <= 1'b0;
                r_shadow <= w_issue ? w_prod : '0;
            end else if (w_issue) begin
                r_shadow <= r_shadow + w_prod;
            end
            if (w_capture) begin
                r_ovf <= (r_shadow >= c_ovf_lim);
            end
        end
    end

    assign result_ovf = r_ovf;
`else
    assign result_ovf = 1'b0;
`endif

    assign busy    = r_busy;
    assign done    = r_done;
    assign result  = r_result;
    assign mac_a   = r_mac_a;
    assign mac_b   = r_mac_b;
    assign mac_acc = r_mac_acc;

endmodule
`default_nettype wire

// File: tb/tb_mac_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mac_operand_feeder
// Description : Self-checking bench for mac_operand_feeder driving a
//               latency-1 behavioural mac (DATA_W=8, DEPTH=8, MAC_LAT=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mac_operand_feeder;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 8;
    localparam int MAC_LAT = 1;

`ifdef FEEDER_OVF_EN
    localparam logic c_ovf_on = 1'b1;
`else
    localparam logic c_ovf_on = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_a;
    logic [7:0]  wr_b;
    logic        start;
    logic [3:0]  len;
    logic        busy;
    logic        done;
    logic [7:0]  result;
    logic        result_ovf;
    logic [7:0]  mac_a;
    logic [7:0]  mac_b;
    logic        mac_acc;
    logic [7:0]  mac_out;
    logic [15:0] mac_prod;

    int checks   = 0;
    int failures = 0;

    mac_operand_feeder #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_a       (wr_a),
        .wr_b       (wr_b),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .result_ovf (result_ovf),
        .mac_a      (mac_a),
        .mac_b      (mac_b),
        .mac_acc    (mac_acc),
        .mac_out    (mac_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural mac: one-cycle latency, truncated multiply-accumulate
    assign mac_prod = 16'(mac_a) * 16'(mac_b);
    always_ff @(posedge clk) begin
        if (reset) mac_out <= '0;
        else       mac_out <= mac_acc ? (mac_out + mac_prod[7:0]) : mac_prod[7:0];
    end

    typedef struct {
        int               nw;
        logic [7:0][7:0]  va;
        logic [7:0][7:0]  vb;
        int               len;
        logic [7:0]       exp_res;
        logic             exp_ovf;
        int               exp_edges;
        int               exp_ones;
        logic             poke;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_entry(input int addr, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'(addr); wr_a = a; wr_b = b;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Wait for done with a bound; returns edges seen after the call point
    task automatic wait_done(output int edges, output int ones);
        edges = 0;
        ones  = 0;
        while (!done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            ones += int'(mac_acc);
        end
    endtask

    // Launch a pass; optionally poke start/wr_en while busy
    task automatic run_pass(input int l, input logic poke, output int edges, output int ones,
                            output logic [7:0] first_a, output logic first_acc, output logic busy0);
        @(negedge clk);
        start = 1'b1; len = 4'(l);
        @(posedge clk); #1;
        start = 1'b0; len = 4'd3;
        first_a = mac_a; first_acc = mac_acc; busy0 = busy;
        edges = 0;
        ones  = int'(mac_acc);
        while (!done && edges < 40) begin
            if (poke && edges == 2) begin
                start = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_a = 8'd100; wr_b = 8'd100;
            end else begin
                start = 1'b0; wr_en = 1'b0;
            end
            @(posedge clk); #1;
            edges++;
            ones += int'(mac_acc);
        end
        start = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        int          edges;
        int          ones;
        logic [7:0]  fa;
        logic        facc;
        logic        b0;

        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0;
        start = 1'b0; len = '0;

        // Vector table
        vecs[0] = '{nw:2, va:'0, vb:'0, len:2,  exp_res:8'd22, exp_ovf:1'b0,     exp_edges:3, exp_ones:1, poke:1'b0};
        vecs[0].va[0] = 8'd3; vecs[0].va[1] = 8'd5; vecs[0].vb[0] = 8'd4; vecs[0].vb[1] = 8'd2;
        vecs[1] = '{nw:0, va:'0, vb:'0, len:0,  exp_res:8'd0,  exp_ovf:1'b0,     exp_edges:1, exp_ones:0, poke:1'b0};
        vecs[2] = '{nw:4, va:'0, vb:'0, len:4,  exp_res:8'd0,  exp_ovf:c_ovf_on, exp_edges:5, exp_ones:3, poke:1'b0};
        for (int i = 0; i < 4; i++) begin vecs[2].va[i] = 8'd16; vecs[2].vb[i] = 8'd16; end
        vecs[3] = '{nw:3, va:'0, vb:'0, len:3,  exp_res:8'd6,  exp_ovf:c_ovf_on, exp_edges:4, exp_ones:2, poke:1'b0};
        vecs[3].va[0] = 8'd255; vecs[3].va[1] = 8'd255; vecs[3].va[2] = 8'd2;
        vecs[3].vb[0] = 8'd255; vecs[3].vb[1] = 8'd1;   vecs[3].vb[2] = 8'd3;
        vecs[4] = '{nw:1, va:'0, vb:'0, len:1,  exp_res:8'd81, exp_ovf:1'b0,     exp_edges:2, exp_ones:0, poke:1'b0};
        vecs[4].va[0] = 8'd9; vecs[4].vb[0] = 8'd9;
        vecs[5] = '{nw:8, va:'0, vb:'0, len:12, exp_res:8'd36, exp_ovf:1'b0,     exp_edges:9, exp_ones:7, poke:1'b1};
        for (int i = 0; i < 8; i++) begin vecs[5].va[i] = 8'(i + 1); vecs[5].vb[i] = 8'd1; end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",    32'(busy),       32'd0);
        check("rst_done",    32'(done),       32'd0);
        check("rst_result",  32'(result),     32'd0);
        check("rst_ovf",     32'(result_ovf), 32'd0);
        check("rst_mac_a",   32'(mac_a),      32'd0);
        check("rst_mac_b",   32'(mac_b),      32'd0);
        check("rst_mac_acc", 32'(mac_acc),    32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven passes
        for (int v = 0; v < 6; v++) begin
            for (int k = 0; k < vecs[v].nw; k++) write_entry(k, vecs[v].va[k], vecs[v].vb[k]);
            run_pass(vecs[v].len, vecs[v].poke, edges, ones, fa, facc, b0);
            check($sformatf("v%0d_busy_e0", v), 32'(b0),   32'd1);
            check($sformatf("v%0d_acc_e0", v),  32'(facc), 32'd0);
            if (vecs[v].len > 0)
                check($sformatf("v%0d_first_a", v), 32'(fa), 32'(vecs[v].va[0]));
            else
                check($sformatf("v%0d_first_a", v), 32'(fa), 32'd0);
            check($sformatf("v%0d_done", v),    32'(done),       32'd1);
            check($sformatf("v%0d_latency", v), 32'(edges),      32'(vecs[v].exp_edges));
            check($sformatf("v%0d_result", v),  32'(result),     32'(vecs[v].exp_res));
            check($sformatf("v%0d_ovf", v),     32'(result_ovf), 32'(vecs[v].exp_ovf));
            check($sformatf("v%0d_acc_ones", v),32'(ones),       32'(vecs[v].exp_ones));
            check($sformatf("v%0d_busy_done", v), 32'(busy),     32'd0);
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse", v), 32'(done),    32'd0);
            check($sformatf("v%0d_result_hold", v), 32'(result), 32'(vecs[v].exp_res));
        end

        // Buffer must be untouched by the write poked while busy: entry 0 is still 1*1
        run_pass(1, 1'b0, edges, ones, fa, facc, b0);
        check("busywr_first_a", 32'(fa),     32'd1);
        check("busywr_result",  32'(result), 32'd1);

        // Write and start on the same idle edge: the pass sees the new entry
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd0; wr_a = 8'd7; wr_b = 8'd8; start = 1'b1; len = 4'd1;
        @(posedge clk); #1;
        wr_en = 1'b0; start = 1'b0;
        check("wrstart_mac_a", 32'(mac_a), 32'd7);
        check("wrstart_mac_b", 32'(mac_b), 32'd8);
        wait_done(edges, ones);
        check("wrstart_latency", 32'(edges),  32'd2);
        check("wrstart_result",  32'(result), 32'd56);
        check("wrstart_acc",     32'(ones),   32'd0);

        // Reset in the middle of a len=4 pass
        for (int k = 0; k < 4; k++) write_entry(k, 8'd16, 8'd16);
        @(negedge clk);
        start = 1'b1; len = 4'd4;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_busy",    32'(busy),       32'd0);
        check("midrst_done",    32'(done),       32'd0);
        check("midrst_result",  32'(result),     32'd0);
        check("midrst_ovf",     32'(result_ovf), 32'd0);
        check("midrst_mac_a",   32'(mac_a),      32'd0);
        check("midrst_mac_b",   32'(mac_b),      32'd0);
        check("midrst_mac_acc", 32'(mac_acc),    32'd0);
        @(negedge clk);
        reset = 1'b0;
        begin
            int seen_done = 0;
            for (int c = 0; c < 8; c++) begin
                @(posedge clk); #1;
                seen_done += int'(done);
            end
            check("midrst_no_done", 32'(seen_done), 32'd0);
        end

        // Re-run the first vector after the abort
        write_entry(0, 8'd3, 8'd4);
        write_entry(1, 8'd5, 8'd2);
        run_pass(2, 1'b0, edges, ones, fa, facc, b0);
        check("rerun_latency", 32'(edges),  32'd3);
        check("rerun_result",  32'(result), 32'd22);
        check("rerun_acc",     32'(ones),   32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
